// File: rtl/sensor_align_pkg.sv
// Shared definitions for the sensor word aligner: word geometry and the
// training state encoding.
package sensor_align_pkg;

    localparam int WORD_W  = 10;
    localparam int SHIFT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_VERIFY = 3'd2,
        ST_LOCKED = 3'd3,
        ST_ERROR  = 3'd4
    } align_state_e;

endpackage

// File: rtl/sensor_word_shifter.sv
// 20->10 window selector: keeps the previous valid word and registers the
// window picked by the current shift offset.
module sensor_word_shifter
    import sensor_align_pkg::*;
(
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [WORD_W-1:0]  data_i,
    input  logic               valid_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [WORD_W-1:0]  window_o,
    output logic [WORD_W-1:0]  data_o,
    output logic               valid_o
);

    logic [WORD_W-1:0]   prev_q;
    logic [WORD_W-1:0]   data_q;
    logic                valid_q;
    logic [2*WORD_W-1:0] span;

    // Bit 0 is the earliest bit, so the older word sits in the low half.
    assign span     = {data_i, prev_q} >> shift_i;
    assign window_o = span[WORD_W-1:0];
    assign data_o   = data_q;
    assign valid_o  = valid_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prev_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                prev_q <= data_i;
                data_q <= window_o;
            end
        end
    end

endmodule

// File: rtl/sensor_word_align.sv
// Word aligner for a 10-bit deserialized sensor stream: sweeps the window
// offset until the training pattern is seen VERIFY_COUNT times in a row.
//
// state  | meaning
// IDLE   | cleared, waiting for in_align_reset to drop
// SEARCH | testing SEARCH_WAIT valid words per offset, then advancing
// VERIFY | pattern seen, counting consecutive matches
// LOCKED | offset frozen, out_align_done high
// ERROR  | MAX_ROTATIONS sweeps without lock, out_align_error high
module sensor_word_align
    import sensor_align_pkg::*;
#(
    parameter int unsigned SEARCH_WAIT   = 4,
    parameter int unsigned VERIFY_COUNT  = 16,
    parameter int unsigned MAX_ROTATIONS = 4
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               in_align_reset,
    input  logic [WORD_W-1:0]  in_align_pattern,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_align_done,
    output logic               out_align_error,
    output logic [SHIFT_W-1:0] out_shift
);

    localparam int WAIT_W  = $clog2(SEARCH_WAIT) + 1;
    localparam int MATCH_W = $clog2(VERIFY_COUNT) + 1;
    localparam int ROT_W   = $clog2(MAX_ROTATIONS) + 1;

    align_state_e       state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d, shift_adv;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [MATCH_W-1:0] match_q, match_d, match_inc;
    logic [ROT_W-1:0]   rot_q, rot_d, rot_adv;
    logic               done_q, error_q;
    logic               shift_wrap, rot_exhausted, hit;
    logic [WORD_W-1:0]  window;

    sensor_word_shifter u_shifter (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .data_i   (in_data),
        .valid_i  (in_valid),
        .shift_i  (shift_q),
        .window_o (window),
        .data_o   (out_data),
        .valid_o  (out_valid)
    );

    assign hit           = (window == in_align_pattern);
    assign shift_wrap    = (shift_q == SHIFT_W'(WORD_W - 1));
    assign shift_adv     = shift_wrap ? '0 : shift_q + 1'b1;
    assign rot_adv       = shift_wrap ? rot_q + 1'b1 : rot_q;
    assign rot_exhausted = (rot_adv == ROT_W'(MAX_ROTATIONS));
    assign match_inc     = match_q + 1'b1;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        wait_d  = wait_q;
        match_d = match_q;
        rot_d   = rot_q;
        case (state_q)
            ST_IDLE: begin
                shift_d = '0;
                wait_d  = '0;
                match_d = '0;
                rot_d   = '0;
                state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (in_valid) begin
                    if (hit) begin
                        match_d = MATCH_W'(1);
                        wait_d  = '0;
                        state_d = (VERIFY_COUNT <= 1) ? ST_LOCKED : ST_VERIFY;
                    end else if (wait_q == WAIT_W'(SEARCH_WAIT - 1)) begin
                        wait_d  = '0;
                        shift_d = shift_adv;
                        rot_d   = rot_adv;
                        if (rot_exhausted) state_d = ST_ERROR;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            ST_VERIFY: begin
                if (in_valid) begin
                    if (hit) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_W'(VERIFY_COUNT)) state_d = ST_LOCKED;
                    end else begin
                        wait_d  = '0;
                        match_d = '0;
                        shift_d = shift_adv;
                        rot_d   = rot_adv;
                        state_d = rot_exhausted ? ST_ERROR : ST_SEARCH;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        // Restart wins over anything the stream did this cycle.
        if (in_align_reset) begin
            state_d = ST_IDLE;
            shift_d = '0;
            wait_d  = '0;
            match_d = '0;
            rot_d   = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            wait_q  <= '0;
            match_q <= '0;
            rot_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            wait_q  <= wait_d;
            match_q <= match_d;
            rot_q   <= rot_d;
            done_q  <= (state_d == ST_LOCKED);
            error_q <= (state_d == ST_ERROR);
        end
    end

    assign out_align_done  = done_q;
    assign out_align_error = error_q;
    assign out_shift       = shift_q;

endmodule

// File: doc/sensor_word_align.md
SENSOR_WORD_ALIGN -- requirements
Module: sensor_word_align

Interface
REQ-001 The block SHALL have these parameters:
  SEARCH_WAIT, default 4, valid words tested per shift position before advancing.
  VERIFY_COUNT, default 16, consecutive matches required to declare lock.
  MAX_ROTATIONS, default 4, full 10-position sweeps allowed before error.
REQ-002 The block SHALL have these ports:
  aclk  input  1  receiver word clock; all logic on rising edge.
  aresetn  input  1  asynchronous, active-low reset.
  in_align_reset  input  1  synchronous restart of training; level, active-high.
  in_align_pattern  input  10  expected training word.
  in_data  input  10  raw deserialized word, bit 0 earliest.
  in_valid  input  1  in_data qualifier.
  out_data  output  10  word-aligned data.
  out_valid  output  1  out_data qualifier.
  out_align_done  output  1  lock achieved.
  out_align_error  output  1  search exhausted.
  out_shift  output  4  current window offset, 0..9.

Function
REQ-003 The block SHALL keep prev = last valid in_data and form window(s) = {in_data, prev}[s+9:s] for s = out_shift.
REQ-004 On each in_valid cycle the block SHALL register out_data <= window(out_shift) and out_valid <= 1; otherwise out_valid <= 0 and out_data holds (latency 1 cycle).
REQ-005 Data pass-through SHALL continue in every state, including before lock and during in_align_reset.
REQ-006 The FSM SHALL have states IDLE, SEARCH, VERIFY, LOCKED, ERROR; counters wait_cnt, match_cnt and rot_cnt advance only on in_valid cycles.
REQ-007 IDLE: shift=0, all counters 0, done=0, error=0; go to SEARCH on the first cycle with in_align_reset=0.
REQ-008 SEARCH, on a valid word:
  - match (window == in_align_pattern): go to VERIFY, match_cnt=1.
  - else if wait_cnt==SEARCH_WAIT-1: wait_cnt=0, advance shift.
  - else: wait_cnt++.
REQ-009 Advancing shift SHALL wrap 9->0 and increment rot_cnt on wrap.
REQ-010 When rot_cnt reaches MAX_ROTATIONS the FSM SHALL go to ERROR.
REQ-011 VERIFY, on a valid word:
  - match: match_cnt++; when it reaches VERIFY_COUNT go to LOCKED.
  - mismatch: go to SEARCH, advance shift (REQ-009 applies), wait_cnt=0, match_cnt=0.
REQ-012 LOCKED SHALL hold shift and assert out_align_done=1 until in_align_reset; later mismatches are ignored.
REQ-013 ERROR SHALL assert out_align_error=1 and hold until in_align_reset.
REQ-014 out_align_done and out_align_error SHALL be registered, asserted the cycle after entering LOCKED/ERROR, and never be high together.
REQ-015 in_align_reset=1 in any state SHALL force IDLE on the next edge and clear done/error that edge; it has priority over same-cycle in_valid events.
REQ-016 A change of in_align_pattern SHALL take effect on the next compare; no restart is implied.
REQ-017 Counter widths SHALL be $clog2 of their limit plus 1; no counter may wrap silently.

Reset
REQ-018 aresetn=0 SHALL immediately set: state IDLE, shift 0, counters 0, prev 0, out_data 0, out_valid 0, out_align_done 0, out_align_error 0.
REQ-019 Reset deassertion mid-stream SHALL begin training from shift 0 on the first valid word.

Structure
REQ-020 The state enum and the word width constant (10) SHALL live in a shared package, sensor_align_pkg.
REQ-021 The 20->10 window selector SHALL be a sub-module, sensor_word_shifter, with a registered output.

Verification
REQ-022 Constant word rotl(0x3a6,3), pattern 0x3a6 -> out_shift=3; out_align_done=1 one cycle after the 28th valid word (12 search + 16 verify); out_data=0x3a6.
REQ-023 All-zero stream -> out_align_error=1 after 160 valid words (10*4*4); out_align_done stays 0.
REQ-024 Lock at shift 3, then a single corrupt word inserted at verify word 8 -> returns to SEARCH at shift 4, wraps, relocks at shift 3; out_align_done is never asserted early.
REQ-025 in_valid toggling 1-0-1 during SEARCH -> same lock result as REQ-022 counted in valid words only; out_valid mirrors in_valid delayed one cycle.
REQ-026 in_align_reset pulse while LOCKED, plus aresetn pulse mid-VERIFY -> done clears next edge (immediately for aresetn), out_shift=0, retraining succeeds.
